elbeth_mux_n_to_1_reg: RTL and testbench

Parametrised N-input, W-bit multiplexer with a registered output stage and a valid/ready handshake on every port; the successor to the fixed 4-bit 2-to-1 combinational mux. It selects among channels either by an external select (MODE 0) or by round-robin arbitration (MODE 1), then holds the chosen word in a one-entry output register until downstream accepts it. It is used wherever several producers share one datapath consumer in the ELBETH pipeline.

---
 rtl/elbeth_mux_n_to_1_reg.sv | 138 +++++++++++++
 tb/tb_elbeth_mux_n_to_1_reg.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_mux_n_to_1_reg.sv
// -----------------------------------------------------------------------------
// elbeth_mux_n_to_1_reg
//
// N-input, W-bit multiplexer with a one-entry registered output stage. Several
// producers share one consumer: a channel is chosen either by an external
// select (MODE 0) or by round-robin arbitration (MODE 1). The chosen word is
// held in the output register until downstream takes it.
//
// Handshake: a word moves across any port on a rising edge where valid and
// ready are both 1 in the cycle before that edge. Producers must hold their
// valid and data steady until they see ready. The output register accepts a new
// word whenever it is empty or is being drained in the same cycle, so a
// continuous stream flows with no bubbles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    flattened input words, channel i at [i*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit set
//   sel        channel select (MODE 0 only)
//   out_data   registered selected word
//   out_chan   index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  downstream accepts the word
// -----------------------------------------------------------------------------
module elbeth_mux_n_to_1_reg #(
    parameter int  DATA_W = 4,
    parameter int  N_IN   = 2,
    parameter int  MODE   = 0,
    localparam int SEL_W  = (N_IN > 2) ? $clog2(N_IN) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_chan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    // One extra bit so rr_ptr + offset can be reduced modulo N_IN without overflow.
    localparam logic [SEL_W:0]   N_IN_EXT = (SEL_W + 1)'(N_IN);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

    logic              can_accept;
    logic              grant_any;
    logic [SEL_W-1:0]  grant_idx;
    logic              xfer;
    logic [DATA_W-1:0] xfer_word;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_next;

    // The register can take a word when it is empty or is emptying this cycle.
    assign can_accept = !out_valid || out_ready;

    // Grant selection: yields a single granted index plus a flag.
    always_comb begin : grant_select
        logic [SEL_W:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (MODE == 0) begin
            // An out-of-range select matches no channel and so grants nothing.
            for (int i = 0; i < N_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Walk the search order rr_ptr, rr_ptr+1, ... backwards so that the
            // earliest valid candidate is the last one written and wins.
            for (int k = N_IN - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
                if (cand >= N_IN_EXT) begin
                    cand = cand - N_IN_EXT;
                end
                if (in_valid[cand[SEL_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[SEL_W-1:0];
                end
            end
        end
    end

    // Ready generation. In MODE 0 ready follows sel alone and ignores in_valid.
    // In MODE 1 ready marks the granted channel. Both are forced low in reset.
    always_comb begin : ready_gen
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (MODE == 0) begin
                in_ready[i] = rst_n && can_accept && (sel == SEL_W'(i));
            end else begin
                in_ready[i] = rst_n && can_accept && grant_any && (grant_idx == SEL_W'(i));
            end
        end
    end

    // A grant is only raised for a valid channel, so grant plus ready is a transfer.
    assign xfer = rst_n && can_accept && grant_any;

    always_comb begin : word_select
        xfer_word = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                xfer_word = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next pointer is one past the granted channel, wrapping N_IN-1 back to 0.
    assign rr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            // Covers both a load into an empty register and load-while-draining.
            out_valid <= 1'b1;
            out_data  <= xfer_word;
            out_chan  <= grant_idx;
            if (MODE != 0) begin
                rr_ptr <= rr_next;
            end
        end else if (out_valid && out_ready) begin
            // Drain only: data and channel keep their last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_elbeth_mux_n_to_1_reg.sv
// -----------------------------------------------------------------------------
// tb_elbeth_mux_n_to_1_reg
//
// Three instances run side by side on one clock and reset:
//   dut 0 : N_IN=4, DATA_W=8, MODE 0 (external select)
//   dut 1 : N_IN=3, DATA_W=8, MODE 0 (out-of-range select reachable)
//   dut 2 : N_IN=3, DATA_W=8, MODE 1 (round-robin)
// A behavioural model per instance predicts ready, transfers and register
// contents from the handshake rules.
// -----------------------------------------------------------------------------
module tb_elbeth_mux_n_to_1_reg;

  logic clk;
  logic rst_n;

  logic [31:0] din [3];
  logic [3:0]  vin [3];
  logic [1:0]  sel_v [3];
  logic [2:0]  oready;

  logic [3:0] rdy_a;
  logic [2:0] rdy_b, rdy_c;
  logic [7:0] od_a, od_b, od_c;
  logic [1:0] oc_a, oc_b, oc_c;
  logic [2:0] ov;

  logic [3:0] rdy [3];
  logic [7:0] od [3];
  logic [1:0] oc [3];
  assign rdy[0] = rdy_a;
  assign rdy[1] = {1'b0, rdy_b};
  assign rdy[2] = {1'b0, rdy_c};
  assign od[0] = od_a;
  assign od[1] = od_b;
  assign od[2] = od_c;
  assign oc[0] = oc_a;
  assign oc[1] = oc_b;
  assign oc[2] = oc_c;

  elbeth_mux_n_to_1_reg #(.DATA_W(8), .N_IN(4), .MODE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy_a),
    .sel(sel_v[0]), .out_data(od_a), .out_chan(oc_a), .out_valid(ov[0]), .out_ready(oready[0])
  );

  elbeth_mux_n_to_1_reg #(.DATA_W(8), .N_IN(3), .MODE(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(din[1][23:0]), .in_valid(vin[1][2:0]), .in_ready(rdy_b),
    .sel(sel_v[1]), .out_data(od_b), .out_chan(oc_b), .out_valid(ov[1]), .out_ready(oready[1])
  );

  elbeth_mux_n_to_1_reg #(.DATA_W(8), .N_IN(3), .MODE(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(din[2][23:0]), .in_valid(vin[2][2:0]), .in_ready(rdy_c),
    .sel(sel_v[2]), .out_data(od_c), .out_chan(oc_c), .out_valid(ov[2]), .out_ready(oready[2])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  // ---------------- reference model ----------------
  logic [2:0] m_valid;
  logic [7:0] m_data [3];
  logic [1:0] m_chan [3];
  int         m_ptr [3];
  logic [9:0] exp_q [$];

  function automatic int n_of(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 3; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = 8'h00;
      m_chan[d]  = 2'd0;
      m_ptr[d]   = 0;
    end
  endfunction

  // Ready the model expects for instance d given the present inputs.
  function automatic logic [3:0] model_ready(int d);
    logic [3:0] r;
    int ch;
    r = 4'h0;
    if (!rst_n) return 4'h0;
    if (m_valid[d] && !oready[d]) return 4'h0;
    if (d != 2) begin
      if (int'(sel_v[d]) < n_of(d)) r[sel_v[d]] = 1'b1;
    end else begin
      for (int k = 0; k < n_of(d); k++) begin
        ch = (m_ptr[d] + k) % n_of(d);
        if (r == 4'h0 && vin[d][ch]) r[ch] = 1'b1;
      end
    end
    return r;
  endfunction

  // Advance one clock edge, updating the model from pre-edge inputs.
  task automatic tick();
    logic [3:0] t;
    int         c [3];
    logic [7:0] w [3];
    logic       drain [3];
    logic       in_rst;
    in_rst = !rst_n;
    for (int d = 0; d < 3; d++) begin
      t = model_ready(d) & vin[d];
      c[d] = -1;
      w[d] = 8'h00;
      for (int i = 0; i < 4; i++) if (t[i]) c[d] = i;
      if (c[d] >= 0) w[d] = din[d][c[d]*8 +: 8];
      drain[d] = m_valid[d] && oready[d];
    end
    @(posedge clk);
    #1;
    if (in_rst) begin
      model_clear();
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (c[d] >= 0) begin
          m_valid[d] = 1'b1;
          m_data[d]  = w[d];
          m_chan[d]  = 2'(c[d]);
          if (d == 2) m_ptr[d] = (c[d] + 1) % n_of(d);
        end else if (drain[d]) begin
          m_valid[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      vin[d]   = 4'h0;
      sel_v[d] = 2'd0;
      din[d]   = 32'h0;
    end
    oready = 3'b111;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    for (int d = 0; d < 3; d++) begin
      vin[d]   = 4'hF;
      sel_v[d] = 2'd1;
      din[d]   = 32'h44332211;
    end
    oready = 3'b111;
    @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      tests_run++;
      if ({ov[d], oc[d], od[d], rdy[d]} !== 15'h0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d: got v=%b ch=%0d d=%h rdy=%b, expected all zero",
                 d, ov[d], oc[d], od[d], rdy[d]);
      end
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (rdy[0] !== 4'b0010) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 0010", rdy[0]);
    end
    tick();
    tests_run++;
    if ({ov[0], oc[0], od[0]} !== {1'b1, 2'd1, 8'h22}) begin
      tests_failed++;
      $display("FAIL reset_first_load: got v=%b ch=%0d d=%h expected v=1 ch=1 d=22", ov[0], oc[0], od[0]);
    end
  endtask

  task automatic test_mode0_stream();
    logic [1:0] sels [3];
    logic [7:0] words [3];
    sels  = '{2'd0, 2'd3, 2'd2};
    words = '{8'h11, 8'h44, 8'h33};
    idle_all();
    din[0]   = 32'h44332211;
    vin[0]   = 4'hF;
    din[1]   = 32'h00CCBBAA;
    vin[1]   = 4'h7;
    sel_v[1] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      sel_v[0] = sels[i];
      #1;
      tests_run++;
      if (rdy[0] !== 4'(1 << sels[i]) || rdy[1] !== 4'h0) begin
        tests_failed++;
        $display("FAIL stream_ready step%0d: got a=%b b=%b expected a=%b b=0000",
                 i, rdy[0], rdy[1], 4'(1 << sels[i]));
      end
      tick();
      tests_run++;
      if ({ov[0], oc[0], od[0]} !== {1'b1, sels[i], words[i]} || ov[1] !== 1'b0) begin
        tests_failed++;
        $display("FAIL stream_out step%0d: got v=%b ch=%0d d=%h bv=%b expected v=1 ch=%0d d=%h bv=0",
                 i, ov[0], oc[0], od[0], ov[1], sels[i], words[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    idle_all();
    sel_v[0] = 2'd2;
    din[0]   = 32'h00A50000;
    vin[0]   = 4'b0100;
    #1;
    tick();
    tests_run++;
    if ({ov[0], oc[0], od[0]} !== {1'b1, 2'd2, 8'hA5}) begin
      tests_failed++;
      $display("FAIL bp_load: got v=%b ch=%0d d=%h expected v=1 ch=2 d=a5", ov[0], oc[0], od[0]);
    end
    oready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel_v[0] = 2'($urandom_range(0, 3));
      din[0]   = $urandom;
      vin[0]   = 4'hF;
      #1;
      tests_run++;
      if (rdy[0] !== 4'h0) begin
        tests_failed++;
        $display("FAIL bp_ready cycle%0d: got %b expected 0000", i, rdy[0]);
      end
      tick();
      tests_run++;
      if ({ov[0], oc[0], od[0]} !== {1'b1, 2'd2, 8'hA5}) begin
        tests_failed++;
        $display("FAIL bp_hold cycle%0d: got v=%b ch=%0d d=%h expected v=1 ch=2 d=a5", i, ov[0], oc[0], od[0]);
      end
    end
    oready[0] = 1'b1;
    sel_v[0]  = 2'd1;
    din[0]    = 32'h00005C00;
    vin[0]    = 4'b0010;
    #1;
    tests_run++;
    if (rdy[0] !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_release_ready: got %b expected 0010", rdy[0]);
    end
    tick();
    tests_run++;
    if ({ov[0], oc[0], od[0]} !== {1'b1, 2'd1, 8'h5C}) begin
      tests_failed++;
      $display("FAIL bp_replace: got v=%b ch=%0d d=%h expected v=1 ch=1 d=5c", ov[0], oc[0], od[0]);
    end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] seq [9];
    seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0};
    idle_all();
    do_reset();
    din[2] = 32'h00C2C1C0;
    for (int i = 0; i < 9; i++) begin
      vin[2] = (i < 6) ? 4'b0111 : 4'b0101;
      #1;
      tests_run++;
      if (rdy[2] !== 4'(1 << seq[i])) begin
        tests_failed++;
        $display("FAIL rr_ready step%0d: got %b expected %b", i, rdy[2], 4'(1 << seq[i]));
      end
      tick();
      tests_run++;
      if ({ov[2], oc[2], od[2]} !== {1'b1, seq[i], 8'hC0 + 8'(seq[i])}) begin
        tests_failed++;
        $display("FAIL rr_grant step%0d: got v=%b ch=%0d d=%h expected ch=%0d", i, ov[2], oc[2], od[2], seq[i]);
      end
    end
  endtask

  task automatic test_rr_ptr_hold();
    vin[2] = 4'b0010;
    #1;
    tick();
    tests_run++;
    if ({ov[2], oc[2]} !== {1'b1, 2'd1}) begin
      tests_failed++;
      $display("FAIL hold_first: got v=%b ch=%0d expected v=1 ch=1", ov[2], oc[2]);
    end
    oready[2] = 1'b0;
    vin[2]    = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (rdy[2] !== 4'h0) begin
        tests_failed++;
        $display("FAIL hold_ready cycle%0d: got %b expected 0000", i, rdy[2]);
      end
      tick();
      tests_run++;
      if ({ov[2], oc[2]} !== {1'b1, 2'd1}) begin
        tests_failed++;
        $display("FAIL hold_stable cycle%0d: got v=%b ch=%0d expected v=1 ch=1", i, ov[2], oc[2]);
      end
    end
    oready[2] = 1'b1;
    vin[2]    = 4'b0110;
    #1;
    tests_run++;
    if (rdy[2] !== 4'b0100) begin
      tests_failed++;
      $display("FAIL hold_release_ready: got %b expected 0100", rdy[2]);
    end
    tick();
    tests_run++;
    if (oc[2] !== 2'd2) begin
      tests_failed++;
      $display("FAIL hold_release_grant: got ch=%0d expected ch=2", oc[2]);
    end
  endtask

  task automatic test_reset_mid_stall();
    oready[2] = 1'b0;
    vin[2]    = 4'b0111;
    #1;
    tick();
    tests_run++;
    if (ov[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_setup: got v=%b expected v=1", ov[2]);
    end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    tests_run++;
    if ({ov[2], oc[2], od[2], rdy[2]} !== 15'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b ch=%0d d=%h rdy=%b expected all zero", ov[2], oc[2], od[2], rdy[2]);
    end
    #1;
    rst_n     = 1'b1;
    oready[2] = 1'b1;
    #1;
    tests_run++;
    if (rdy[2] !== 4'b0001) begin
      tests_failed++;
      $display("FAIL post_reset_ready: got %b expected 0001", rdy[2]);
    end
    tick();
    tests_run++;
    if ({ov[2], oc[2]} !== {1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL post_reset_grant: got v=%b ch=%0d expected v=1 ch=0", ov[2], oc[2]);
    end
  endtask

  task automatic test_random();
    logic [3:0] t;
    logic [9:0] exp_w;
    logic       pushed;
    int         c;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int d = 0; d < 3; d++) begin
        vin[d]    = 4'($urandom_range(0, 15));
        sel_v[d]  = 2'($urandom_range(0, 3));
        din[d]    = $urandom;
        oready[d] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        tests_run++;
        if (rdy[d] !== model_ready(d)) begin
          tests_failed++;
          $display("FAIL rand_ready cyc%0d dut%0d: got %b expected %b", cyc, d, rdy[d], model_ready(d));
        end
      end
      t = model_ready(2) & vin[2];
      pushed = 1'b0;
      if (t != 4'h0) begin
        c = 0;
        for (int i = 0; i < 4; i++) if (t[i]) c = i;
        exp_q.push_back({2'(c), din[2][c*8 +: 8]});
        pushed = 1'b1;
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        tests_run++;
        if ({ov[d], oc[d], od[d]} !== {m_valid[d], m_chan[d], m_data[d]}) begin
          tests_failed++;
          $display("FAIL rand_out cyc%0d dut%0d: got v=%b ch=%0d d=%h expected v=%b ch=%0d d=%h",
                   cyc, d, ov[d], oc[d], od[d], m_valid[d], m_chan[d], m_data[d]);
        end
      end
      if (pushed) begin
        exp_w = exp_q.pop_front();
        tests_run++;
        if ({oc[2], od[2]} !== exp_w) begin
          tests_failed++;
          $display("FAIL rand_scoreboard cyc%0d: got ch=%0d d=%h expected ch=%0d d=%h",
                   cyc, oc[2], od[2], exp_w[9:8], exp_w[7:0]);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle_all();
    model_clear();
    test_reset();
    test_mode0_stream();
    test_backpressure();
    test_rr_fairness();
    test_rr_ptr_hold();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
